// File: rtl/instr_fetch_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instr_fetch_seq: PC, req/ack instruction fetch, one-at-a-time sequencing  |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module instr_fetch_seq #(
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int              CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   output logic             imem_req,
   output logic [PC_W-1:0]  imem_addr,
   input  logic             imem_ack,
   input  logic [7:0]       imem_rdata,
   output logic [7:0]       instr,
   output logic [2:0]       opcode,
   output logic [4:0]       imm5,
   output logic             instr_valid,
   input  logic             exec_done,
   input  logic             jump,
   input  logic             branch,
   input  logic             zero,
   output logic [PC_W-1:0]  pc,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_DECODE = 2'd2,
      ST_EXEC   = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [7:0]       instr_q, instr_d;
   logic [CNT_W-1:0] retired_q, retired_d;

   logic             taken;
   logic [PC_W-1:0]  imm_sext;
   logic [PC_W-1:0]  pc_seq;

   // Branch offset is relative to the sequential successor, not to pc itself.
   assign taken    = jump | (branch & zero);
   assign imm_sext = PC_W'($signed(instr_q[4:0]));
   assign pc_seq   = pc_q + PC_W'(1);

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      retired_d = retired_q;
      case (state_q)
         ST_IDLE: begin
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (imem_ack) begin
               instr_d = imem_rdata;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            if (exec_done) begin
               pc_d      = taken ? (pc_seq + imm_sext) : pc_seq;
               retired_d = retired_q + CNT_W'(1);
               state_d   = ST_FETCH;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         pc_q      <= RESET_PC;
         instr_q   <= 8'h00;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         retired_q <= retired_d;
      end
   end

   assign imem_req    = (state_q == ST_FETCH);
   assign imem_addr   = pc_q;
   assign instr_valid = (state_q == ST_DECODE);
   assign instr       = instr_q;
   assign opcode      = instr_q[7:5];
   assign imm5        = instr_q[4:0];
   assign pc          = pc_q;
   assign retired     = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_seq.sv
`default_nettype none
// Randomized bench for instr_fetch_seq against a transaction-level PC/counter model.
module tb_instr_fetch_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_ack;
   logic [7:0]  imem_rdata;
   logic [7:0]  instr;
   logic [2:0]  opcode;
   logic [4:0]  imm5;
   logic        instr_valid;
   logic        exec_done;
   logic        jump;
   logic        branch;
   logic        zero;
   logic [7:0]  pc;
   logic [15:0] retired;

   int total = 0;
   int bad   = 0;
   int exp_pc;
   int exp_ret;
   logic [7:0] mem [256];

   always #5 clk = ~clk;

   instr_fetch_seq dut (
      .clk        (clk),
      .reset      (reset),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .instr      (instr),
      .opcode     (opcode),
      .imm5       (imm5),
      .instr_valid(instr_valid),
      .exec_done  (exec_done),
      .jump       (jump),
      .branch     (branch),
      .zero       (zero),
      .pc         (pc),
      .retired    (retired)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // One full instruction: fetch with ack_dly wait states, decode, exec_dly idle
   // exec cycles, then retire with the given jump/branch/zero controls.
   task automatic run_instr(input int ack_dly, input int exec_dly,
                            input bit j, input bit b, input bit z, input bit spur);
      int         n;
      int         off;
      bit         tk;
      logic [7:0] ins;
      n = 0;
      while (imem_req !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("req_seen", {31'd0, imem_req}, 32'd1);
      chk("fetch_addr", imem_addr, exp_pc);
      chk("pc_fetch", pc, exp_pc);
      for (int i = 0; i < ack_dly; i++) begin
         if (spur) begin
            exec_done = 1'($urandom_range(0, 1));
            jump      = 1'($urandom_range(0, 1));
            branch    = 1'($urandom_range(0, 1));
            zero      = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         exec_done = 1'b0;
         chk("req_hold", {31'd0, imem_req}, 32'd1);
         chk("addr_hold", imem_addr, exp_pc);
         chk("no_valid_wait", {31'd0, instr_valid}, 32'd0);
         chk("pc_wait", pc, exp_pc);
      end
      ins        = mem[exp_pc];
      imem_ack   = 1'b1;
      imem_rdata = ins;
      @(negedge clk);
      imem_ack   = 1'b0;
      imem_rdata = 8'($urandom);
      chk("valid_pulse", {31'd0, instr_valid}, 32'd1);
      chk("instr", instr, ins);
      chk("opcode", opcode, ins[7:5]);
      chk("imm5", imm5, ins[4:0]);
      chk("req_drop", {31'd0, imem_req}, 32'd0);
      @(negedge clk);
      chk("valid_once", {31'd0, instr_valid}, 32'd0);
      for (int i = 0; i < exec_dly; i++) begin
         if (spur) begin
            imem_ack   = 1'($urandom_range(0, 1));
            imem_rdata = 8'($urandom);
         end
         @(negedge clk);
         imem_ack = 1'b0;
         chk("instr_exec_hold", instr, ins);
         chk("pc_exec_hold", pc, exp_pc);
         chk("no_valid_exec", {31'd0, instr_valid}, 32'd0);
         chk("no_req_exec", {31'd0, imem_req}, 32'd0);
         chk("retired_hold", retired, exp_ret);
      end
      exec_done = 1'b1;
      jump      = j;
      branch    = b;
      zero      = z;
      @(negedge clk);
      exec_done = 1'b0;
      jump      = 1'($urandom_range(0, 1));
      branch    = 1'($urandom_range(0, 1));
      zero      = 1'($urandom_range(0, 1));
      off = int'(ins[4:0]);
      if (off >= 16) off = off - 32;
      tk      = j | (b & z);
      exp_pc  = (exp_pc + 1 + (tk ? off : 0)) & 255;
      exp_ret = (exp_ret + 1) % 65536;
      chk("pc_next", pc, exp_pc);
      chk("retired", retired, exp_ret);
      chk("refetch_req", {31'd0, imem_req}, 32'd1);
   endtask

   task automatic run_random(input int count);
      for (int k = 0; k < count; k++) begin
         run_instr($urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      #300us;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
      mem[0]    = 8'h40;
      mem[1]    = 8'h41;
      mem[2]    = 8'h42;
      mem[3]    = 8'h06;  // jump +6 -> 10
      mem[10]   = 8'hDD;  // branch -3
      mem[8]    = 8'h01;  // jump +1 -> 10
      mem[11]   = 8'h10;  // jump -16 -> FC
      mem[8'hFC] = 8'hAF; // jump +15 -> 0C wraps

      reset      = 1'b1;
      imem_ack   = 1'b0;
      imem_rdata = 8'h00;
      exec_done  = 1'b0;
      jump       = 1'b0;
      branch     = 1'b0;
      zero       = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_pc", pc, 32'h00);
      chk("rst_instr", instr, 32'h00);
      chk("rst_retired", retired, 32'd0);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      exp_pc  = 0;
      exp_ret = 0;
      reset   = 1'b0;
      @(negedge clk);

      run_instr(0, 0, 0, 0, 0, 0);
      run_instr(0, 0, 0, 0, 0, 0);
      run_instr(0, 0, 0, 0, 0, 0);
      run_instr(0, 0, 1, 0, 0, 0);
      run_instr(4, 0, 0, 1, 1, 1);
      run_instr(0, 2, 1, 0, 0, 1);
      run_instr(0, 0, 0, 1, 0, 0);
      run_instr(1, 1, 1, 1, 0, 1);
      run_instr(0, 0, 1, 0, 0, 0);
      chk("wrap_pc", pc, 32'h0C);

      run_random(150);

      // Reset in the middle of a fetch, with an ack landing on the same edge.
      imem_ack   = 1'b1;
      imem_rdata = 8'hFF;
      reset      = 1'b1;
      @(negedge clk);
      reset    = 1'b0;
      imem_ack = 1'b0;
      exp_pc   = 0;
      exp_ret  = 0;
      chk("midrst_pc", pc, 32'h00);
      chk("midrst_req", {31'd0, imem_req}, 32'd0);
      chk("midrst_instr", instr, 32'h00);
      chk("midrst_retired", retired, 32'd0);
      chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
      @(negedge clk);
      chk("restart_req", {31'd0, imem_req}, 32'd1);
      chk("restart_addr", imem_addr, 32'h00);

      run_random(20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
